// File: rtl/lfsr_pkg.sv
// lfsr_pkg: definitions shared by the LFSR control stage and the LFSR/display stage.
//   LFSR_W       - LFSR register width
//   SEED_RESET   - seed presented to the LFSR after reset (non-zero so the LFSR runs)
//   ctrl_state_e - states of the step/load sequencer
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] SEED_RESET = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StGap,
        StLoadSetup,
        StLoadPulse,
        StLoadHold
    } ctrl_state_e;

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// lfsr_step_ctrl_if: control bundle from the step controller to the LFSR stage.
//   step - LFSR clock pulse
//   set  - LFSR loads seed on the next step rise while high
//   seed - seed value to load
//   busy - controller is sequencing a step or a load
// Modports: master (controller drives), slave (LFSR stage observes).
interface lfsr_step_ctrl_if;
    import lfsr_pkg::*;

    logic              step;
    logic              set;
    logic [LFSR_W-1:0] seed;
    logic              busy;

    modport master (output step, output set, output seed, output busy);
    modport slave  (input step, input set, input seed, input busy);

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces one raw push-button.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous bouncy button, active-high
//   level - accepted (debounced) button level
//   rise  - single-cycle pulse in the cycle the accepted level turns 1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the accepted level, so any
    // bounce back to the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    // Combinational so the request lands in the pending flag on the same edge the level updates.
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: turns raw buttons/switches into a clean step clock and seed-load controls.
//   clk      - system clock
//   rst      - synchronous active-high reset
//   btn_step - raw step button (bouncy, async)
//   btn_load - raw load button (bouncy, async)
//   sw_seed  - seed switches, captured when a load starts
//   sw_auto  - auto-run enable (async, synchronised only)
//   lfsr     - master side of the control bundle (step, set, seed, busy), all registered
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned AUTO_DIV        = 25000000,
    parameter int unsigned STEP_HIGH       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              btn_load,
    input  logic [LFSR_W-1:0] sw_seed,
    input  logic              sw_auto,
    lfsr_step_ctrl_if.master  lfsr
);

    localparam int unsigned AutoW  = $clog2(AUTO_DIV);
    localparam int unsigned PhaseW = $clog2(STEP_HIGH + 1);

    // Button front ends.
    logic step_level, load_level;
    logic step_rise, load_rise;
    logic unused_levels;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_step (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_step),
        .level(step_level),
        .rise (step_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_load (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_load),
        .level(load_level),
        .rise (load_rise)
    );

    assign unused_levels = step_level ^ load_level;

    // Auto-run divider.
    logic             auto_s1_q, auto_s2_q;
    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
    logic             auto_req;

    assign auto_req = auto_s2_q && (auto_cnt_q == AutoW'(AUTO_DIV - 1));

    always_comb begin
        auto_cnt_d = '0;
        if (auto_s2_q && !auto_req) begin
            auto_cnt_d = auto_cnt_q + AutoW'(1);
        end
    end

    // Pending flags and sequencer.
    ctrl_state_e       state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              phase_last;
    logic              step_pend_q, step_pend_d;
    logic              load_pend_q, load_pend_d;
    logic              step_serve, load_serve;

    logic              step_q, step_d;
    logic              set_q, set_d;
    logic              busy_q, busy_d;
    logic [LFSR_W-1:0] seed_q, seed_d;

    assign phase_last = (phase_q == PhaseW'(STEP_HIGH - 1));

    // A request arriving in the serve cycle re-arms the flag; otherwise requests merge.
    assign step_pend_d = (step_pend_q & ~step_serve) | step_rise | auto_req;
    assign load_pend_d = (load_pend_q & ~load_serve) | load_rise;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic; phase_q counts cycles spent in the timed states.
    always_comb begin
        state_d    = state_q;
        phase_d    = '0;
        step_serve = 1'b0;
        load_serve = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Load wins; a coincident step stays pending until after the load.
                if (load_pend_q) begin
                    state_d    = StLoadSetup;
                    load_serve = 1'b1;
                end else if (step_pend_q) begin
                    state_d    = StPulse;
                    step_serve = 1'b1;
                end
            end
            StPulse: begin
                if (phase_last) state_d = StGap;
                else            phase_d = phase_q + PhaseW'(1);
            end
            StGap: begin
                if (phase_last) state_d = StIdle;
                else            phase_d = phase_q + PhaseW'(1);
            end
            StLoadSetup: begin
                state_d = StLoadPulse;
            end
            StLoadPulse: begin
                if (phase_last) state_d = StLoadHold;
                else            phase_d = phase_q + PhaseW'(1);
            end
            StLoadHold: begin
                if (phase_last) state_d = StIdle;
                else            phase_d = phase_q + PhaseW'(1);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic, decoded from the next state so every output is a flop.
    always_comb begin
        step_d = (state_d == StPulse) || (state_d == StLoadPulse);
        set_d  = state_d inside {StLoadSetup, StLoadPulse, StLoadHold};
        busy_d = (state_d != StIdle);
        seed_d = seed_q;
        if (load_serve) begin
            seed_d = sw_seed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_s1_q   <= 1'b0;
            auto_s2_q   <= 1'b0;
            auto_cnt_q  <= '0;
            step_pend_q <= 1'b0;
            load_pend_q <= 1'b0;
            step_q      <= 1'b0;
            set_q       <= 1'b0;
            busy_q      <= 1'b0;
            seed_q      <= SEED_RESET;
        end else begin
            auto_s1_q   <= sw_auto;
            auto_s2_q   <= auto_s1_q;
            auto_cnt_q  <= auto_cnt_d;
            step_pend_q <= step_pend_d;
            load_pend_q <= load_pend_d;
            step_q      <= step_d;
            set_q       <= set_d;
            busy_q      <= busy_d;
            seed_q      <= seed_d;
        end
    end

    assign lfsr.step = step_q;
    assign lfsr.set  = set_q;
    assign lfsr.busy = busy_q;
    assign lfsr.seed = seed_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// tb_lfsr_step_ctrl: directed bench for lfsr_step_ctrl with small debounce/divider settings.
module tb_lfsr_step_ctrl;
    import lfsr_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned DIV = 10;
    localparam int unsigned SH  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_step = 1'b0;
    logic       btn_load = 1'b0;
    logic       sw_auto = 1'b0;
    logic [7:0] sw_seed = 8'h00;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int rise_cnt  = 0;
    int base;
    logic step_prev = 1'b0;

    lfsr_step_ctrl_if bus ();

    lfsr_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_DIV       (DIV),
        .STEP_HIGH      (SH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_step(btn_step),
        .btn_load(btn_load),
        .sw_seed (sw_seed),
        .sw_auto (sw_auto),
        .lfsr    (bus)
    );

    always #5 clk = ~clk;

    // Count step rising edges, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.step && !step_prev) rise_cnt <= rise_cnt + 1;
        step_prev <= bus.step;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic st, input logic se,
                             input logic [7:0] sd, input logic bz);
        check({tag, ".step"}, 32'(bus.step), 32'(st));
        check({tag, ".set"},  32'(bus.set),  32'(se));
        check({tag, ".seed"}, 32'(bus.seed), 32'(sd));
        check({tag, ".busy"}, 32'(bus.busy), 32'(bz));
    endtask

    initial begin
        // Reset and quiescence.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_out("reset", 1'b0, 1'b0, 8'h01, 1'b0);
        tick(5);
        check_out("quiet", 1'b0, 1'b0, 8'h01, 1'b0);

        // Bouncy step press: toggle for 6 cycles, final edge to 1, hold.
        base = rise_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_step = (i % 2 == 0);
            tick(1);
        end
        btn_step = 1'b1;
        tick(6);
        check_out("bounce_n6", 1'b0, 1'b0, 8'h01, 1'b0);
        tick(1);
        check_out("bounce_n7", 1'b1, 1'b0, 8'h01, 1'b1);
        tick(1);
        check("bounce_n8.step", 32'(bus.step), 32'd1);
        tick(1);
        check_out("bounce_gap", 1'b0, 1'b0, 8'h01, 1'b1);
        tick(17);
        check("bounce_rises", 32'(rise_cnt - base), 32'd1);
        btn_step = 1'b0;
        tick(20);
        check("release_rises", 32'(rise_cnt - base), 32'd1);

        // Clean load of 8'hA5, with sw_seed changing mid-load.
        sw_seed  = 8'hA5;
        btn_load = 1'b1;
        tick(6);
        check_out("load_n6", 1'b0, 1'b0, 8'h01, 1'b0);
        tick(1);
        check_out("load_setup", 1'b0, 1'b1, 8'hA5, 1'b1);
        sw_seed = 8'h3C;
        tick(1);
        check_out("load_pulse0", 1'b1, 1'b1, 8'hA5, 1'b1);
        tick(1);
        check_out("load_pulse1", 1'b1, 1'b1, 8'hA5, 1'b1);
        tick(1);
        check_out("load_hold0", 1'b0, 1'b1, 8'hA5, 1'b1);
        tick(1);
        check_out("load_hold1", 1'b0, 1'b1, 8'hA5, 1'b1);
        tick(1);
        check_out("load_done", 1'b0, 1'b0, 8'hA5, 1'b0);
        btn_load = 1'b0;
        tick(15);
        check("load_seed_held", 32'(bus.seed), 32'h0A5);

        // Auto-run for 100 cycles: first rise 13 edges in, then every 10.
        base    = rise_cnt;
        sw_auto = 1'b1;
        tick(12);
        check("auto_n12.step", 32'(bus.step), 32'd0);
        tick(1);
        check("auto_n13.step", 32'(bus.step), 32'd1);
        tick(87);
        sw_auto = 1'b0;
        tick(10);
        check("auto_rises", 32'(rise_cnt - base), 32'd10);
        tick(30);
        check("auto_off_rises", 32'(rise_cnt - base), 32'd10);
        check("auto_off_busy", 32'(bus.busy), 32'd0);

        // Load and step requested together: load first, step after one idle cycle.
        base     = rise_cnt;
        sw_seed  = 8'h5A;
        btn_step = 1'b1;
        btn_load = 1'b1;
        tick(7);
        check_out("coll_setup", 1'b0, 1'b1, 8'h5A, 1'b1);
        tick(5);
        check_out("coll_idle", 1'b0, 1'b0, 8'h5A, 1'b0);
        tick(1);
        check_out("coll_step", 1'b1, 1'b0, 8'h5A, 1'b1);
        tick(2);
        check_out("coll_gap", 1'b0, 1'b0, 8'h5A, 1'b1);
        tick(8);
        check("coll_rises", 32'(rise_cnt - base), 32'd2);
        btn_step = 1'b0;
        btn_load = 1'b0;
        tick(15);

        // Reset during LOAD_PULSE with a step still pending.
        sw_seed  = 8'hC3;
        btn_step = 1'b1;
        btn_load = 1'b1;
        tick(8);
        check_out("rst_pre", 1'b1, 1'b1, 8'hC3, 1'b1);
        rst      = 1'b1;
        btn_step = 1'b0;
        btn_load = 1'b0;
        tick(1);
        check_out("rst_mid", 1'b0, 1'b0, 8'h01, 1'b0);
        rst  = 1'b0;
        base = rise_cnt;
        tick(25);
        check("rst_no_pending", 32'(rise_cnt - base), 32'd0);
        check_out("rst_after", 1'b0, 1'b0, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", check_cnt - fail_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/lfsr_step_ctrl.md
Name: lfsr_step_ctrl

Overview:
- Upstream control stage for the 8-bit LFSR/7-segment display stage.
- Turns raw push-buttons and switches into clean LFSR control: a glitch-free `step` pulse that the LFSR uses as its clock, plus `set`/`seed` for seed loading.
- Supports manual single-step and an auto-run mode driven by a programmable divider.
- Guarantees that `set` and `seed` are stable around every `step` rising edge used for a load.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles before a button level is accepted.
- AUTO_DIV, 25000000, clk cycles between auto-run step requests; must be ≥2.
- STEP_HIGH, 4, width of each `step` high phase in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_step  in  1  raw step button (asynchronous, bouncy, active-high)
- btn_load  in  1  raw load button (asynchronous, bouncy, active-high)
- sw_seed  in  8  seed switches (quasi-static)
- sw_auto  in  1  auto-run enable switch (asynchronous)
- step  out  1  registered step pulse; downstream LFSR clock
- set  out  1  registered; high means the LFSR loads `seed` on the next `step` rise
- seed  out  8  registered seed value presented to the LFSR
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: step=0, set=0, seed=8'h01, busy=0. On reset, the FSM returns to IDLE, pending requests clear, and debounce and divider counters clear to 0.
- Reset mid-sequence: `step` and `set` drop on the next edge. No partial pulse is stretched.
- Debounce, per button:
  - 2-flop synchroniser feeds a counter.
  - The counter increments while the synced level differs from the accepted level and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES-1, the accepted level updates.
  - A rising edge of the accepted level produces a 1-cycle request.
  - A held button yields exactly one request.
  - `sw_auto` passes through a 2-flop synchroniser only (no debounce).
- Auto divider:
  - While synced sw_auto=1, the counter runs 0..AUTO_DIV-1 and raises an auto request when it wraps.
  - When sw_auto=0, the counter is held at 0 and no requests are generated.
- Pending flags: one step-pending flag and one load-pending flag, each 1 deep.
  - Each is set by its request and cleared when the FSM serves it.
  - Further requests while a flag is already set are merged into it.
- FSM states:
  - IDLE: if load-pending, go to LOAD_SETUP and capture seed<=sw_seed. Else if step-pending, go to PULSE. Load has priority.
  - PULSE: step=1 for STEP_HIGH cycles, then GAP.
  - GAP: step=0 for STEP_HIGH cycles, then IDLE.
  - LOAD_SETUP: set=1, step=0 for 1 cycle, then LOAD_PULSE.
  - LOAD_PULSE: set=1, step=1 for STEP_HIGH cycles, then LOAD_HOLD.
  - LOAD_HOLD: set=1, step=0 for STEP_HIGH cycles. Then set=0 and go to IDLE.
- Latency: a step request accepted in IDLE at edge N gives step=1 from edge N+1.
- Step rate: at most one step rise every 2·STEP_HIGH+1 cycles.
- `seed` changes only in the transition IDLE→LOAD_SETUP. It holds otherwise, including when sw_seed changes mid-load.
- sw_seed=0 is loaded unchanged; zero-state recovery is the LFSR's job.
- Simultaneous load and step requests: the load is served first and the step stays pending. It fires one GAP-free IDLE cycle after LOAD_HOLD.
- sw_auto falling while a PULSE is in progress: the current pulse completes, and an already-pending auto step is still served.

Decomposition:
- Shared package `lfsr_pkg`:
  - FSM state enum.
  - LFSR_W=8 and SEED_RESET=8'h01 (shared with the LFSR stage).
- One natural sub-module, `btn_debounce`:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, raw, level, rise.
  - Instantiated for btn_step and btn_load.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_DIV=10, STEP_HIGH=2):
- Reset: assert rst for 2 cycles with buttons idle → step=0, set=0, seed=8'h01, busy=0. These hold with no activity.
- Bounce: btn_step toggles every cycle for 6 cycles, then holds at 1 for 20 cycles → exactly one step pulse (2 cycles high), first high 2+4+1 cycles after the last toggle. Releasing the button produces no pulse.
- Load:
  - Stimulus: sw_seed=8'hA5, press btn_load cleanly.
  - Required: seed=8'hA5 and set=1 one cycle before step rises.
  - Required: set stays 1 through the 2-cycle step high and the 2 cycles after it.
  - Required: changing sw_seed to 8'h3C mid-load leaves seed=8'hA5.
- Auto: sw_auto=1 for 100 cycles → step rises every 10 cycles (10 rises). After sw_auto=0 there are no further rises.
- Collision: load and step requests in the same cycle → full load sequence first, then one plain step pulse with set=0 starting in the IDLE cycle after LOAD_HOLD.
- Reset mid-load: rst asserted during LOAD_PULSE → step=0 and set=0 at the next edge, seed=8'h01, pending flags clear.
